// File: rtl/column_scheduler_if.sv
// Bus between the audio level sampler/controller and the LED column scheduler.
// The master drives the sample stream and controls; the slave is the scheduler.
interface column_scheduler_if;
  logic [11:0] sample;
  logic        sample_valid;
  logic        run;
  logic        freeze;
  logic        set;
  logic [11:0] result;
  logic [3:0]  col_count;
  logic [3:0]  hold_level;
  logic        busy;

  modport master (
    output sample, sample_valid, run, freeze,
    input  set, result, col_count, hold_level, busy
  );

  modport slave (
    input  sample, sample_valid, run, freeze,
    output set, result, col_count, hold_level, busy
  );
endinterface

// File: rtl/column_scheduler.sv
// Reduces each column period of ADC samples to a bar level 0..14, issues one
// set pulse per period to the LED column shift register, and tracks peak hold.
module column_scheduler #(
  parameter int CYCLES_PER_COL = 2500000,
  parameter int HOLD_COLS      = 8,
  parameter int MIDSCALE       = 2048
) (
  input logic               clk,
  input logic               reset_n,
  column_scheduler_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] QUANT = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int              TW        = $clog2(CYCLES_PER_COL);
  localparam logic [TW-1:0]   TICK_LAST = TW'(CYCLES_PER_COL - 4);
  localparam logic [11:0]     MID       = 12'(MIDSCALE);
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_COLS);

  logic [2:0]    state;
  logic [TW-1:0] tick;
  logic [11:0]   peak;
  logic [11:0]   dev;
  logic [3:0]    level;
  logic [3:0]    level_next;
  logic [3:0]    result_q;
  logic [3:0]    col_q;
  logic [3:0]    hold_q;
  logic [3:0]    hold_next;
  logic [7:0]    timer;
  logic [7:0]    timer_next;
  logic          issue;

  // Both branches fit in 12 bits: the larger deviation is MID itself.
  always_comb begin
    dev = 12'd0;
    if (bus.sample >= MID) dev = bus.sample - MID;
    else                   dev = MID - bus.sample;
  end

  assign level_next = (peak[11:7] > 5'd14) ? 4'd14 : peak[10:7];

  // The pulse and its data appear together during ISSUE and are committed
  // on the edge that ends it, so freeze and run are judged in ISSUE itself.
  assign issue = (state == ISSUE) && bus.run && !bus.freeze;

  always_comb begin
    hold_next  = hold_q;
    timer_next = timer;
    if (level >= hold_q) begin
      hold_next  = level;
      timer_next = HOLD_INIT;
    end else if (timer != 8'd0) begin
      timer_next = timer - 8'd1;
    end else if (hold_q != 4'd0) begin
      hold_next = hold_q - 4'd1;
    end
  end

  assign bus.set        = issue;
  assign bus.result     = issue ? {8'd0, level} : {8'd0, result_q};
  assign bus.col_count  = issue ? col_q + 4'd1 : col_q;
  assign bus.hold_level = issue ? hold_next : hold_q;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick     <= '0;
      peak     <= 12'd0;
      level    <= 4'd0;
      result_q <= 4'd0;
      col_q    <= 4'd0;
      hold_q   <= 4'd0;
      timer    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          peak <= 12'd0;
          tick <= '0;
          if (bus.run) state <= ACCUM;
        end
        ACCUM: begin
          if (!bus.run) begin
            state <= IDLE;
            peak  <= 12'd0;
            tick  <= '0;
          end else begin
            if (bus.sample_valid && (dev > peak)) peak <= dev;
            tick <= tick + 1'b1;
            if (tick == TICK_LAST) state <= QUANT;
          end
        end
        QUANT: begin
          if (!bus.run) begin
            state <= IDLE;
          end else begin
            level <= level_next;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.run) begin
            state <= IDLE;
          end else begin
            if (issue) begin
              result_q <= level;
              col_q    <= col_q + 4'd1;
              hold_q   <= hold_next;
              timer    <= timer_next;
            end
            state <= GAP;
          end
        end
        GAP: begin
          peak  <= 12'd0;
          tick  <= '0;
          state <= bus.run ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_scheduler.sv
// Self-checking bench for column_scheduler: vector tables, corner sequences
// and randomized traffic against a column-level reference model.
module tb_column_scheduler;

  localparam int N    = 8;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic reset_n;

  column_scheduler_if bus ();

  column_scheduler #(
    .CYCLES_PER_COL(N),
    .HOLD_COLS     (HOLD),
    .MIDSCALE      (2048)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: whether a window is open, position within the column
  // period, running window maximum deviation, and the committed outputs.
  bit m_active;
  int m_pos, m_max, m_result, m_count, m_hold, m_timer;

  bit obs_set, obs_busy;
  int obs_result, obs_count, obs_hold;
  int cyc, last_set_cyc;

  typedef struct {
    logic [11:0] base;
    int          spike_pos;
    logic [11:0] spike;
    int          exp_level;
  } quant_vec_t;

  quant_vec_t qv[7];
  int hold_levels[6];
  int hold_expect[6];

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_max = 0;
    m_result = 0; m_count = 0; m_hold = 0; m_timer = 0;
    last_set_cyc = -1;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic apply_stimulus(input logic [11:0] s, input bit v, input bit r, input bit f);
    bit exp_set;
    int lvl, dv, nh, nt, exp_res, exp_cnt, exp_hold;
    bus.sample = s; bus.sample_valid = v; bus.run = r; bus.freeze = f;
    @(negedge clk);
    obs_set = bus.set; obs_busy = bus.busy;
    obs_result = int'(bus.result); obs_count = int'(bus.col_count); obs_hold = int'(bus.hold_level);

    exp_set = m_active && (m_pos == N - 2) && r && !f;
    lvl = (m_max / 128 > 14) ? 14 : m_max / 128;
    nh = m_hold; nt = m_timer;
    if (lvl >= m_hold) begin nh = lvl; nt = HOLD; end
    else if (m_timer != 0) nt = m_timer - 1;
    else nh = (m_hold > 0) ? m_hold - 1 : 0;
    exp_res  = exp_set ? lvl : m_result;
    exp_cnt  = exp_set ? (m_count + 1) % 16 : m_count;
    exp_hold = exp_set ? nh : m_hold;

    check_output("set", int'(obs_set), int'(exp_set));
    check_output("result", obs_result, exp_res);
    check_output("col_count", obs_count, exp_cnt);
    check_output("hold_level", obs_hold, exp_hold);
    check_output("busy", int'(obs_busy), int'(m_active));
    if (obs_set) begin
      if (last_set_cyc >= 0) check_output("set_spacing_ok", int'(cyc - last_set_cyc >= N), 1);
      last_set_cyc = cyc;
    end

    if (!m_active) begin
      if (r) begin m_active = 1; m_pos = 0; m_max = 0; end
    end else if (!r && m_pos <= N - 2) begin
      m_active = 0;
    end else begin
      if (m_pos <= N - 4 && v) begin
        dv = int'(s) - 2048;
        if (dv < 0) dv = -dv;
        if (dv > m_max) m_max = dv;
      end
      if (exp_set) begin
        m_result = lvl; m_count = exp_cnt; m_hold = nh; m_timer = nt;
      end
      if (m_pos == N - 1) begin
        if (r) begin m_pos = 0; m_max = 0; end
        else m_active = 0;
      end else begin
        m_pos++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    reset_n = 1'b0;
    bus.run = 1'b1; bus.sample_valid = 1'b1; bus.freeze = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      bus.sample = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (i > 0) begin
        check_output("rst_set", int'(bus.set), 0);
        check_output("rst_result", int'(bus.result), 0);
        check_output("rst_col_count", int'(bus.col_count), 0);
        check_output("rst_hold_level", int'(bus.hold_level), 0);
        check_output("rst_busy", int'(bus.busy), 0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // One column period starting from IDLE (optionally without the IDLE entry
  // cycle); run drops in GAP so the scheduler returns to IDLE afterwards.
  task automatic run_window(input logic [11:0] base, input int spike_pos, input logic [11:0] spike,
                            input bit frz, input bit with_idle,
                            output bit got, output int lvl, output int set_pos);
    got = 0; lvl = -1; set_pos = -1;
    if (with_idle) apply_stimulus(12'd2048, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < N; p++) begin
      apply_stimulus((p == spike_pos) ? spike : base, 1'b1, (p != N - 1), frz);
      if (obs_set) begin got = 1; lvl = obs_result; set_pos = p; end
    end
  endtask

  initial begin
    bit got;
    int lvl, pos, nsets;
    int set_rel[$];
    int set_cnt[$];

    qv[0] = '{12'd2688, -1, 12'd0, 5};
    qv[1] = '{12'd4095, -1, 12'd0, 14};
    qv[2] = '{12'd0,    -1, 12'd0, 14};
    qv[3] = '{12'd1920, -1, 12'd0, 1};
    qv[4] = '{12'd2175, -1, 12'd0, 0};
    qv[5] = '{12'd2048, N - 4, 12'd4095, 14};
    qv[6] = '{12'd2048, N - 3, 12'd4095, 0};
    hold_levels = '{10, 3, 3, 3, 3, 12};
    hold_expect = '{10, 10, 10, 9, 8, 12};

    cyc = 0;
    reset_n = 1'b0;
    bus.sample = 12'd2048; bus.sample_valid = 1'b1; bus.run = 1'b1; bus.freeze = 1'b0;
    @(posedge clk);
    #1;
    do_reset(5);

    // Steady midscale: pulses at ACCUM-relative 6, 14, 22.
    apply_stimulus(12'd2048, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3 * N; c++) begin
      apply_stimulus(12'd2048, 1'b1, (c != 3 * N - 1), 1'b0);
      if (obs_set) begin set_rel.push_back(c); set_cnt.push_back(obs_count); end
    end
    check_output("midscale_num_sets", set_rel.size(), 3);
    for (int i = 0; i < 3 && i < set_rel.size(); i++) begin
      check_output("midscale_set_pos", set_rel[i], N - 2 + i * N);
      check_output("midscale_col_count", set_cnt[i], i + 1);
    end
    check_output("midscale_result", obs_result, 0);

    for (int i = 0; i < 7; i++) begin
      run_window(qv[i].base, qv[i].spike_pos, qv[i].spike, 1'b0, 1'b1, got, lvl, pos);
      check_output("quant_got_set", int'(got), 1);
      check_output("quant_level", lvl, qv[i].exp_level);
    end

    // Freeze across one ISSUE, then a normal period.
    run_window(12'd4095, -1, 12'd0, 1'b1, 1'b1, got, lvl, pos);
    check_output("freeze_no_set", int'(got), 0);
    check_output("freeze_col_count", obs_count, 10);
    check_output("freeze_result", obs_result, 0);
    run_window(12'd2688, -1, 12'd0, 1'b0, 1'b1, got, lvl, pos);
    check_output("after_freeze_level", lvl, 5);
    check_output("after_freeze_col_count", obs_count, 11);

    // Abort in ACCUM cycle 2, then a fresh window on re-entry.
    apply_stimulus(12'd2048, 1'b0, 1'b1, 1'b0);
    apply_stimulus(12'd4095, 1'b1, 1'b1, 1'b0);
    apply_stimulus(12'd4095, 1'b1, 1'b1, 1'b0);
    apply_stimulus(12'd4095, 1'b1, 1'b0, 1'b0);
    check_output("abort_no_set", int'(obs_set), 0);
    apply_stimulus(12'd2048, 1'b0, 1'b1, 1'b0);
    check_output("abort_idle_busy", int'(obs_busy), 0);
    run_window(12'd2688, -1, 12'd0, 1'b0, 1'b0, got, lvl, pos);
    check_output("reentry_set_pos", pos, N - 2);
    check_output("reentry_level", lvl, 5);

    // Mid-window reset, then 17 columns for the col_count wrap.
    apply_stimulus(12'd2048, 1'b1, 1'b1, 1'b0);
    apply_stimulus(12'd4095, 1'b1, 1'b1, 1'b0);
    do_reset(3);
    nsets = 0;
    apply_stimulus(12'd2048, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 17 * N; c++) begin
      apply_stimulus(12'($urandom_range(1800, 2300)), 1'b1, (c != 17 * N - 1), 1'b0);
      if (obs_set) begin
        nsets++;
        if (nsets == 16) check_output("wrap_col16", obs_count, 0);
        if (nsets == 17) check_output("wrap_col17", obs_count, 1);
      end
    end
    check_output("wrap_num_sets", nsets, 17);

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      run_window(12'(2048 + hold_levels[i] * 128), -1, 12'd0, 1'b0, 1'b1, got, lvl, pos);
      check_output("hold_col_level", lvl, hold_levels[i]);
      check_output("hold_level_seq", obs_hold, hold_expect[i]);
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [11:0] s;
      s = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                      : 12'($urandom_range(1500, 2600));
      apply_stimulus(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0),
                     ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_scheduler.md
# column_scheduler

Sequences the LED column shift register that drives the audio level display. It measures the microphone ADC sample stream over a fixed column period and reduces each period to a peak deviation from midscale. It quantises that peak to a bar level 0..14 and issues one `set` pulse with the level on `result`, spaced so the shift register sees exactly one shift per period. It also maintains a decaying peak-hold level for a marker overlay.

## Interface
- CYCLES_PER_COL, default 2500000: clock cycles per display column. Must be ≥ 4.
- HOLD_COLS, default 8: columns a new peak-hold value is held before decay starts. Range 0..255.
- MIDSCALE, default 2048: ADC zero-signal code.

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- sample  in  12  unsigned ADC code
- sample_valid  in  1  `sample` is valid this cycle
- run  in  1  enable; low forces IDLE
- freeze  in  1  suppress column issue; the display holds still
- set  out  1  one-cycle pulse: shift `result` into the pattern
- result  out  12  bar level, always 0..14 (bits 11:4 are 0)
- col_count  out  4  columns issued, mod 16
- hold_level  out  4  peak-hold level 0..14
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, QUANT, ISSUE, GAP.
- Reset: state IDLE. `set`=0, `result`=0, `col_count`=0, `hold_level`=0, internal peak=0, tick=0, hold timer=0.
- IDLE
  - `set`=0; peak and tick cleared.
  - On `run`=1, go to ACCUM with tick=0.
- ACCUM
  - Each cycle with `sample_valid`: dev = |sample − MIDSCALE|, computed 13-bit then held in 12 bits (max 2048). peak ← max(peak, dev).
  - tick increments every cycle. After tick = CYCLES_PER_COL−4, go to QUANT. ACCUM therefore lasts CYCLES_PER_COL−3 cycles.
  - A sample on the last ACCUM cycle is included.
- QUANT (1 cycle)
  - level = min(peak >> 7, 14); registered.
  - Samples are ignored.
- ISSUE (1 cycle)
  - If `freeze`=0: `set`=1, `result`=level, `col_count` += 1 (wraps 15→0), and the peak-hold update runs.
  - If `freeze`=1: `set`=0; `result`, `col_count` and hold are unchanged.
  - Samples are ignored.
- GAP (1 cycle)
  - `set`=0; peak cleared; tick=0.
  - Then go to ACCUM, or to IDLE if `run`=0.
  - The downstream register captures on `set` and shifts on the following non-`set` cycle, so consecutive `set` pulses must be ≥2 cycles apart. GAP guarantees this.
- Peak-hold update, on an issued column only:
  - If level ≥ `hold_level`: `hold_level` ← level, timer ← HOLD_COLS.
  - Else if timer ≠ 0: timer −= 1.
  - Else: `hold_level` −= 1, saturating at 0.
- `run`=0 in ACCUM, QUANT or ISSUE: go to IDLE next cycle, with no `set` and the partial window discarded. `col_count`, `result` and hold are retained.
- `result` holds its last issued value between pulses.

## Timing
- Column period is exactly CYCLES_PER_COL cycles: ACCUM (N−3) + QUANT + ISSUE + GAP.
- The first ACCUM cycle is the cycle after `run` is sampled high in IDLE.
- `set` rises on ACCUM-relative cycle N−2, then every N cycles.
- Latency from the last window sample to `set` is 2 cycles.
- `result`, `col_count` and `hold_level` update on the same edge that raises `set`.
- `set` is never high on two consecutive cycles, and never high in IDLE, ACCUM, QUANT or GAP.
- `freeze` and `run` are sampled in the state that uses them; there is no other latching.
- Synchronous reset mid-window wins over all other activity: every output takes its reset value on the next edge.

## Test plan
All scenarios use N=8, HOLD_COLS=2.

1. Reset: hold `reset_n`=0 with `run`=1 and valid samples → `set`=0, `result`=0, `col_count`=0, `hold_level`=0, `busy`=0 throughout.
2. Steady midscale: `run`=1, `sample`=2048 every cycle → `set` pulses at ACCUM-relative cycles 6, 14, 22; `result`=0; `col_count` 1, 2, 3.
3. Quantisation, one window each:
   - 2688 → 5
   - 4095 → 14 (2047>>7 = 15, clamped)
   - 0 → 14 (dev 2048)
   - 1920 → 1
   - 2048+127 → 0
   - A 4095 sample on the last ACCUM cycle is counted; the same sample in QUANT is ignored and the next window gives 0.
4. Wrap and spacing: run 17 columns → `col_count` reads 0 after column 16 and 1 after column 17. No two `set` cycles closer than 8 cycles.
5. Freeze and run abort:
   - `freeze`=1 across one ISSUE → no `set`; `col_count` and `result` unchanged; next period normal.
   - Drop `run` in ACCUM cycle 2 → IDLE next cycle, no pulse. Re-raise `run` → fresh window; first `set` 6 cycles after re-entering ACCUM, level from new samples only.
6. Hold decay: levels 10, 3, 3, 3, 3, 12 → `hold_level` sequence 10, 10, 10, 9, 8, 12.
